// File: rtl/iter_shifter_if.sv
// Handshake and data bundle for the iterative shift unit.
// The requester (execute stage) uses the master side; the shifter uses the slave side.
interface iter_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) ();
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               result_valid;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, data_in, shamt,
        input  busy, result_valid, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, result_valid, result
    );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shift unit: SLL / SRL / SRA / ROR by a runtime amount,
// moving at most STEP bit positions per clock, with start/busy/result_valid handshake.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic          clock,
    input  logic          reset,
    iter_shifter_if.slave bus
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Step amounts need one extra bit so that STEP == WIDTH is representable.
    localparam logic [SHAMT_W:0] STEP_AMT = (SHAMT_W+1)'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   work_reg;
    logic [1:0]         op_reg;
    logic [SHAMT_W-1:0] rem_reg;
    logic               sign_reg;
    logic [WIDTH-1:0]   result_reg;

    logic               load;
    logic [SHAMT_W:0]   rem_ext;
    logic [SHAMT_W:0]   amt;
    logic [SHAMT_W:0]   rem_left;
    logic [WIDTH-1:0]   step_val;

    // Candidate results for every constant amount 1..STEP under the latched op.
    logic [STEP:1][WIDTH-1:0] cand;

    assign rem_ext  = {1'b0, rem_reg};
    assign amt      = (rem_ext > STEP_AMT) ? STEP_AMT : rem_ext;
    assign rem_left = rem_ext - amt;

    genvar gi;
    generate
        for (gi = 1; gi <= STEP; gi++) begin : g_amt
            if (gi < WIDTH) begin : g_part
                assign cand[gi] =
                    (op_reg == OP_SLL) ? {work_reg[WIDTH-1-gi:0], {gi{1'b0}}} :
                    (op_reg == OP_SRL) ? {{gi{1'b0}}, work_reg[WIDTH-1:gi]} :
                    (op_reg == OP_SRA) ? {{gi{sign_reg}}, work_reg[WIDTH-1:gi]} :
                                         {work_reg[gi-1:0], work_reg[WIDTH-1:gi]};
            end else begin : g_full
                // A full-width move: logical shifts empty the word, SRA floods
                // it with the sign, rotate returns the original word.
                assign cand[gi] =
                    (op_reg == OP_SRA) ? {WIDTH{sign_reg}} :
                    (op_reg == OP_ROR) ? work_reg : '0;
            end
        end
    endgenerate

    // Select the candidate matching this cycle's step amount.
    always_comb begin
        step_val = work_reg;
        for (int i = 1; i <= STEP; i++) begin
            if (amt == (SHAMT_W+1)'(i)) begin
                step_val = cand[i];
            end
        end
    end

    // Next-state logic; load marks acceptance of a new request.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = (bus.shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (rem_left == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Working datapath; result is captured on the edge entering DONE so it
    // is already valid during the result_valid cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            work_reg   <= '0;
            op_reg     <= '0;
            rem_reg    <= '0;
            sign_reg   <= 1'b0;
            result_reg <= '0;
        end else if (load) begin
            work_reg <= bus.data_in;
            op_reg   <= bus.op;
            rem_reg  <= bus.shamt;
            sign_reg <= bus.data_in[WIDTH-1];
            if (bus.shamt == '0) begin
                result_reg <= bus.data_in;
            end
        end else if (state_reg == S_SHIFT) begin
            work_reg <= step_val;
            rem_reg  <= rem_left[SHAMT_W-1:0];
            if (rem_left == '0) begin
                result_reg <= step_val;
            end
        end
    end

    assign bus.busy         = (state_reg != S_IDLE);
    assign bus.result_valid = (state_reg == S_DONE);
    assign bus.result       = result_reg;
endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: three instances (STEP = 1, 4, 32) share one stimulus
// stream; directed scenarios observe the STEP=4 instance, the random sweep all three.
module tb_iter_shifter;
    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;

    int vectors;
    int miscompares;

    iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus1 ();
    iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus4 ();
    iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus32 ();

    assign bus1.start  = start;  assign bus1.op  = op;  assign bus1.data_in  = data_in;  assign bus1.shamt  = shamt;
    assign bus4.start  = start;  assign bus4.op  = op;  assign bus4.data_in  = data_in;  assign bus4.shamt  = shamt;
    assign bus32.start = start;  assign bus32.op = op;  assign bus32.data_in = data_in;  assign bus32.shamt = shamt;

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1))  dut1  (.clock(clock), .reset(reset), .bus(bus1.slave));
    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4.slave));
    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));

    logic        valid_v  [3];
    logic        busy_v   [3];
    logic [31:0] result_v [3];
    int          steps    [3] = '{1, 4, 32};

    assign valid_v[0] = bus1.result_valid;  assign busy_v[0] = bus1.busy;  assign result_v[0] = bus1.result;
    assign valid_v[1] = bus4.result_valid;  assign busy_v[1] = bus4.busy;  assign result_v[1] = bus4.result;
    assign valid_v[2] = bus32.result_valid; assign busy_v[2] = bus32.busy; assign result_v[2] = bus32.result;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; afterwards outputs reflect the new cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single-cycle reference behaviour of the four operations.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int s);
        logic [31:0] r;
        case (o)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = 32'($signed(d) >>> s);
            default: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input int s, input int st);
        return 1 + (s + st - 1) / st;
    endfunction

    // Hold start for one cycle (cycle t); returns positioned in cycle t+1.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input int s);
        op      = o;
        data_in = d;
        shamt   = 5'(s);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Wait (bounded) for the STEP=4 result_valid; lat is the cycle offset from t.
    task automatic wait_valid4(output int lat);
        lat = 1;
        while (!valid_v[1] && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b1;
        op      = 2'b00;
        data_in = $urandom;
        shamt   = 5'd3;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (busy_v[k] !== 1'b0 || valid_v[k] !== 1'b0 || result_v[k] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_state step=%0d busy=%b valid=%b result=%h required 0/0/00000000",
                         steps[k], busy_v[k], valid_v[k], result_v[k]);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        vectors++;
        if (busy_v[1] !== 1'b0 || valid_v[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy=%b valid=%b required 0/0", busy_v[1], valid_v[1]);
        end
        $display("reset: done");
    endtask

    task automatic test_sra_step();
        issue(2'b10, 32'hF000_0000, 4);
        vectors++;
        if (busy_v[1] !== 1'b1 || valid_v[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sra_t1 busy=%b valid=%b required 1/0", busy_v[1], valid_v[1]);
        end
        tick();
        vectors++;
        if (valid_v[1] !== 1'b1 || busy_v[1] !== 1'b1 || result_v[1] !== 32'hFF00_0000) begin
            miscompares++;
            $display("FAIL sra_t2 valid=%b busy=%b result=%h required 1/1/ff000000",
                     valid_v[1], busy_v[1], result_v[1]);
        end
        tick();
        vectors++;
        if (valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || result_v[1] !== 32'hFF00_0000) begin
            miscompares++;
            $display("FAIL sra_t3 valid=%b busy=%b result=%h required 0/0/ff000000",
                     valid_v[1], busy_v[1], result_v[1]);
        end
        $display("sra_step: op=SRA d=f0000000 sh=4 result=%h", result_v[1]);
    endtask

    task automatic test_srl_full();
        int lat;
        issue(2'b01, 32'h8000_0000, 31);
        wait_valid4(lat);
        vectors++;
        if (lat !== 9 || result_v[1] !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL srl_full lat=%0d result=%h required 9/00000001", lat, result_v[1]);
        end
        $display("srl_full: lat=%0d result=%h", lat, result_v[1]);
        tick();
        issue(2'b10, 32'h8000_0000, 31);
        wait_valid4(lat);
        vectors++;
        if (lat !== 9 || result_v[1] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL sra_full lat=%0d result=%h required 9/ffffffff", lat, result_v[1]);
        end
        $display("sra_full: lat=%0d result=%h", lat, result_v[1]);
        tick();
    endtask

    task automatic test_zero_rotate();
        int lat;
        issue(2'b00, 32'h1234_5678, 0);
        wait_valid4(lat);
        vectors++;
        if (lat !== 1 || result_v[1] !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL zero_shift lat=%0d result=%h required 1/12345678", lat, result_v[1]);
        end
        $display("zero_shift: lat=%0d result=%h", lat, result_v[1]);
        tick();
        issue(2'b11, 32'h0000_0001, 5);
        wait_valid4(lat);
        vectors++;
        if (lat !== 3 || result_v[1] !== 32'h0800_0000) begin
            miscompares++;
            $display("FAIL rotate lat=%0d result=%h required 3/08000000", lat, result_v[1]);
        end
        $display("rotate: lat=%0d result=%h", lat, result_v[1]);
        tick();
    endtask

    task automatic test_busy_ignore();
        issue(2'b00, 32'h0000_0001, 8);          // now t+1
        op = 2'b00; data_in = 32'h0000_FFFF; shamt = 5'd1; start = 1'b1;
        tick();                                   // t+2
        start = 1'b0;
        vectors++;
        if (valid_v[1] !== 1'b0 || busy_v[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_t2 valid=%b busy=%b required 0/1", valid_v[1], busy_v[1]);
        end
        tick();                                   // t+3 (DONE)
        vectors++;
        if (valid_v[1] !== 1'b1 || result_v[1] !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL busy_done valid=%b result=%h required 1/00000100", valid_v[1], result_v[1]);
        end
        start = 1'b1;                             // start during DONE, then held into IDLE
        tick();                                   // t+4 (IDLE, start accepted here)
        vectors++;
        if (valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || result_v[1] !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL busy_idle valid=%b busy=%b result=%h required 0/0/00000100",
                     valid_v[1], busy_v[1], result_v[1]);
        end
        tick();                                   // t+5
        start = 1'b0;
        vectors++;
        if (busy_v[1] !== 1'b1 || valid_v[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_restart busy=%b valid=%b required 1/0", busy_v[1], valid_v[1]);
        end
        tick();                                   // t+6
        vectors++;
        if (valid_v[1] !== 1'b1 || result_v[1] !== 32'h0001_FFFE) begin
            miscompares++;
            $display("FAIL busy_second valid=%b result=%h required 1/0001fffe", valid_v[1], result_v[1]);
        end
        $display("busy_ignore: second result=%h", result_v[1]);
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(2'b01, $urandom | 32'h8000_0000, 20);   // t+1
        tick();                                        // t+2
        reset = 1'b1;
        tick();                                        // t+3
        reset = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            vectors++;
            if (busy_v[1] !== 1'b0 || valid_v[1] !== 1'b0 || result_v[1] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_mid cycle=t+%0d busy=%b valid=%b result=%h required 0/0/00000000",
                         c, busy_v[1], valid_v[1], result_v[1]);
            end
            tick();
        end
        issue(2'b00, 32'h0000_00A5, 3);
        wait_valid4(lat);
        vectors++;
        if (lat !== 2 || result_v[1] !== 32'h0000_0528) begin
            miscompares++;
            $display("FAIL reset_mid_resume lat=%0d result=%h required 2/00000528", lat, result_v[1]);
        end
        $display("reset_mid: resume lat=%0d result=%h", lat, result_v[1]);
        tick();
    endtask

    task automatic test_random_sweep();
        logic [1:0]  o;
        logic [31:0] d;
        logic [31:0] expv;
        int          s;
        int          c;
        int          lat   [3];
        logic [31:0] got   [3];
        int          pulses[3];
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int n = 0; n < 2000; n++) begin
            o    = 2'($urandom_range(0, 3));
            d    = $urandom;
            s    = $urandom_range(0, 31);
            expv = ref_shift(o, d, s);
            for (int k = 0; k < 3; k++) begin
                lat[k] = 0; got[k] = 'x; pulses[k] = 0;
            end
            issue(o, d, s);
            c = 1;
            forever begin
                for (int k = 0; k < 3; k++) begin
                    if (valid_v[k]) begin
                        pulses[k]++;
                        if (lat[k] == 0) begin
                            lat[k] = c;
                            got[k] = result_v[k];
                        end
                    end
                end
                if ((lat[0] != 0 && lat[1] != 0 && lat[2] != 0) || c >= 40) break;
                // Operand inputs wander while the operation is in flight.
                op = 2'($urandom_range(0, 3)); data_in = $urandom; shamt = 5'($urandom_range(0, 31));
                tick();
                c++;
            end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got[k] !== expv || lat[k] !== ref_latency(s, steps[k]) || pulses[k] !== 1) begin
                    miscompares++;
                    $display("FAIL rand step=%0d op=%0d d=%h sh=%0d result=%h lat=%0d pulses=%0d required %h/%0d/1",
                             steps[k], o, d, s, got[k], lat[k], pulses[k], expv, ref_latency(s, steps[k]));
                end
            end
            if (n % 250 == 0)
                $display("rand #%0d: op=%0d d=%h sh=%0d exp=%h", n, o, d, s, expv);
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        op          = 2'b00;
        data_in     = '0;
        shamt       = '0;
        test_reset();
        test_sra_step();
        test_srl_full();
        test_zero_rotate();
        test_busy_ignore();
        test_reset_mid();
        test_random_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle, parametrised shift unit for the processor ALU path.
- Replaces the fixed-amount shift blocks with one unit. It performs SLL, SRL, SRA or ROR by a runtime amount, moving at most STEP bit positions per clock.
- Uses a start/busy/result_valid handshake, so the execute stage treats it like the multdiv unit and stalls while busy.

Parameters:
- WIDTH, 32: datapath width in bits. Must be a power of two, 8 or more.
- SHAMT_W, 5: shift-amount width. Must equal log2(WIDTH).
- STEP, 4: maximum bit positions shifted per cycle. Must be a power of two, 1 to WIDTH.

Ports:
- clock  in  1  : single clock, all state updates on the rising edge.
- reset  in  1  : synchronous, active-high. Returns the unit to IDLE.
- start  in  1  : request a shift. Sampled only in IDLE.
- op  in  2  : operation select. 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- data_in  in  WIDTH  : operand. Latched when start is accepted.
- shamt  in  SHAMT_W  : shift amount, 0 to WIDTH-1. Latched when start is accepted.
- busy  out  1  : high in SHIFT and DONE.
- result_valid  out  1  : one-cycle pulse when result is final.
- result  out  WIDTH  : shifted value. Registered.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0; result_valid=0; result=0; internal operand, op and remaining-count registers cleared.
  - Reset wins over every other input, including a coincident start.
  - Reset asserted mid-operation aborts it. No result_valid pulse is produced for the aborted request.
- IDLE:
  - busy=0.
  - start=1 latches data_in, op and shamt into the working register, op register and rem register.
  - shamt=0: next state DONE. Otherwise next state SHIFT.
- SHIFT:
  - Each cycle, amt = min(STEP, rem). The working register is shifted by amt according to the latched op; rem <= rem - amt.
  - When rem - amt = 0, next state is DONE. Otherwise stay in SHIFT.
- Fill rules:
  - SLL fills low bits with 0.
  - SRL fills high bits with 0.
  - SRA fills high bits with bit WIDTH-1 of the original latched operand. The sign is preserved across every step.
  - ROR wraps low bits into high bits.
- Per-step shifter: a combinational mux over amounts 1 to STEP. No variable-amount shift operator wider than STEP.
- DONE:
  - result <= working register; result_valid=1 for exactly this one cycle; busy=1.
  - Next state IDLE unconditionally.
- Latency:
  - start accepted in cycle t, result_valid high in cycle t+1+ceil(shamt/STEP).
  - shamt=0 gives t+1.
  - WIDTH=32, STEP=4, shamt=31 gives t+9.
- Handshake:
  - start while busy=1 is ignored, with no queueing. This includes start coincident with result_valid, because DONE is busy.
  - start is accepted in the first IDLE cycle after DONE.
- result holds its value from DONE until the next DONE or reset. It is not cleared on a new start.
- op and data_in changing after acceptance has no effect on an operation in flight.
- Exact equivalence required: for any input, the output must equal the single-cycle reference behaviour (Verilog << / >> / >>> / rotate) on the latched operands.

Test Plan:
- SRA by one step: reset 2 cycles, then start with op=10, data_in=0xF0000000, shamt=4 (STEP=4). Required: result=0xFF000000 and result_valid pulse at t+2; busy high t+1..t+2.
- SRL full-range: op=01, data_in=0x80000000, shamt=31. Required: result=0x00000001, valid at t+9. Then op=10 on the same data. Required: result=0xFFFFFFFF, valid at t+9.
- Zero shift and rotate:
  - op=00, data_in=0x12345678, shamt=0. Required: result=0x12345678 at t+1.
  - op=11, data_in=0x00000001, shamt=5. Required: result=0x08000000 at t+3.
- Start ignored while busy: start SLL data 0x1, shamt=8. Pulse start again at t+1 and at the DONE cycle with data 0xFFFF, shamt=1. Required: only result=0x00000100 at t+3, no second result_valid. A start in the following IDLE cycle is accepted.
- Reset mid-operation: start SRL shamt=20, assert reset at t+2. Required: busy=0, result=0, and no result_valid through t+10. A new start after reset completes normally.
- Randomised sweep against the single-cycle operator model: 2000 ops, all four op codes, shamt 0..31, with STEP=1, 4 and 32. Required: zero mismatches, and latency exactly 1+ceil(shamt/STEP) every time.
